// File: rtl/em_buf_alloc_arb_pkg.sv
// Shared types and constants for the edit-memory buffer allocator.
// Supplies fallback values for the codebase reset-name and pointer-width macros.
`ifndef RESET_SIG
`define RESET_SIG rst_n
`endif
`ifndef EM_BUF_PTR_NBITS
`define EM_BUF_PTR_NBITS 4
`endif

package em_buf_alloc_arb_pkg;

    localparam int PTR_NBITS      = `EM_BUF_PTR_NBITS;
    localparam int PEND_NBITS_DEF = 4;
    localparam int PEND_MAX       = (1 << PEND_NBITS_DEF) - 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic [PTR_NBITS-1:0] ptr;
        logic                 available;
    } resp_t;

endpackage

// File: rtl/em_buf_freelist.sv
// Circular free list of buffer pointers with an init-write port and count.
// A push into a full list is a double free: it is dropped and reported.
module em_buf_freelist
    import em_buf_alloc_arb_pkg::*;
#(
    parameter int BPTR_NBITS = PTR_NBITS
) (
    input  logic                  clk,
    input  logic                  `RESET_SIG,
    input  logic                  init_we,
    input  logic [BPTR_NBITS-1:0] init_ptr,
    input  logic                  push,
    input  logic [BPTR_NBITS-1:0] push_ptr,
    input  logic                  pop,
    output logic [BPTR_NBITS-1:0] head_ptr,
    output logic [BPTR_NBITS:0]   count
);

    localparam int NUM_BUFS = 1 << BPTR_NBITS;
    localparam logic [BPTR_NBITS:0]   CNT_FULL = (BPTR_NBITS+1)'(NUM_BUFS);
    localparam logic [BPTR_NBITS:0]   CNT_ONE  = (BPTR_NBITS+1)'(1);
    localparam logic [BPTR_NBITS-1:0] IDX_ONE  = BPTR_NBITS'(1);

    logic [BPTR_NBITS-1:0] mem [NUM_BUFS];
    logic [BPTR_NBITS-1:0] rd_idx;
    logic [BPTR_NBITS-1:0] wr_idx;
    logic                  wr_en;
    logic                  rd_en;
    logic [BPTR_NBITS-1:0] wr_data;

    always_comb begin
        rd_en   = pop && (count != '0);
        wr_en   = init_we || (push && (count != CNT_FULL));
        wr_data = init_we ? init_ptr : push_ptr;
    end

    assign head_ptr = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!`RESET_SIG) begin
            rd_idx <= '0;
            wr_idx <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_idx <= wr_idx + IDX_ONE;
            if (rd_en) rd_idx <= rd_idx + IDX_ONE;
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Double free is dropped above; flagged as a warning so the pool stays consistent.
    always_ff @(posedge clk) begin
        if (`RESET_SIG) begin
            assert (!(push && (count == CNT_FULL)))
            else $warning("em_buf_freelist: double free of ptr %0d dropped", push_ptr);
        end
    end

endmodule

// File: rtl/em_buf_alloc_arb.sv
// Edit-memory buffer allocator: round-robin arbiter over pending pointer requests.
// Optional statistics outputs are built when EM_BUF_ALLOC_STATS_EN is defined.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | writing pointers 0..NUM_BUFS-1 into the free list; no grants
// ST_RUN  | arbitrating pending tokens; left only through reset
module em_buf_alloc_arb
    import em_buf_alloc_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int BPTR_NBITS = PTR_NBITS,
    parameter int PEND_NBITS = PEND_NBITS_DEF
) (
    input  logic                  clk,
    input  logic                  `RESET_SIG,
    input  logic [NUM_REQ-1:0]    req,
    input  logic                  free_valid,
    input  logic [BPTR_NBITS-1:0] free_ptr,
    output logic [NUM_REQ-1:0]    buf_valid,
    output logic [BPTR_NBITS-1:0] buf_ptr,
    output logic                  buf_available,
    output logic [BPTR_NBITS:0]   free_cnt,
    output logic                  init_done,
    output logic                  pend_ovf
`ifdef EM_BUF_ALLOC_STATS_EN
    ,
    output logic [31:0]           stat_alloc_cnt,
    output logic [31:0]           stat_empty_cnt,
    output logic [BPTR_NBITS:0]   stat_low_water
`endif
);

    localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PEND_NBITS-1:0] PMAX     = '1;
    localparam logic [PEND_NBITS-1:0] PEND_ONE = PEND_NBITS'(1);
    localparam logic [RR_W-1:0]       RR_ONE   = RR_W'(1);

    state_t                state;
    logic [BPTR_NBITS-1:0] init_cnt;
    logic [PEND_NBITS-1:0] pend [NUM_REQ];
    logic [RR_W-1:0]       rr_ptr;
    resp_t                 resp_q;
    logic [RR_W-1:0]       resp_idx;

    logic                  grant;
    logic [RR_W-1:0]       winner;
    logic [RR_W-1:0]       cand;
    logic [NUM_REQ-1:0]    gnt_vec;
    logic                  pop;
    logic                  push;
    logic [BPTR_NBITS-1:0] head_ptr;

    em_buf_freelist #(
        .BPTR_NBITS(BPTR_NBITS)
    ) u_freelist (
        .clk       (clk),
        .`RESET_SIG(`RESET_SIG),
        .init_we   (state == ST_INIT),
        .init_ptr  (init_cnt),
        .push      (push),
        .push_ptr  (free_ptr),
        .pop       (pop),
        .head_ptr  (head_ptr),
        .count     (free_cnt)
    );

    always_ff @(posedge clk) begin
        if (!`RESET_SIG) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + BPTR_NBITS'(1);
                    if (init_cnt == '1) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                ST_RUN: state <= ST_RUN;
            endcase
        end
    end

    // First requester with a pending token at or after rr_ptr, wrapping.
    always_comb begin
        grant  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = RR_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!grant && (pend[cand] != '0)) begin
                grant  = 1'b1;
                winner = cand;
            end
        end
        if (state != ST_RUN) grant = 1'b0;
        gnt_vec = grant ? (NUM_REQ'(1) << winner) : '0;
        pop     = grant && (free_cnt != '0);
        push    = free_valid && (state == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (!`RESET_SIG) begin
            for (int r = 0; r < NUM_REQ; r++) pend[r] <= '0;
            pend_ovf <= 1'b0;
            rr_ptr   <= '0;
        end else begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (req[r] && !gnt_vec[r]) begin
                    if (pend[r] == PMAX) pend_ovf <= 1'b1;
                    else                 pend[r]  <= pend[r] + PEND_ONE;
                end else if (!req[r] && gnt_vec[r]) begin
                    pend[r] <= pend[r] - PEND_ONE;
                end
            end
            if (grant) begin
                rr_ptr <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + RR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!`RESET_SIG) begin
            resp_q   <= '0;
            resp_idx <= '0;
        end else begin
            resp_q.valid     <= grant;
            resp_q.available <= pop;
            resp_q.ptr       <= pop ? head_ptr : '0;
            if (grant) resp_idx <= winner;
        end
    end

    always_comb begin
        buf_valid     = resp_q.valid ? (NUM_REQ'(1) << resp_idx) : '0;
        buf_ptr       = resp_q.ptr;
        buf_available = resp_q.available;
    end

    always_ff @(posedge clk) begin
        if (`RESET_SIG && (state == ST_INIT)) begin
            assert (!free_valid)
            else $error("em_buf_alloc_arb: buffer returned during free-list init");
        end
    end

`ifdef EM_BUF_ALLOC_STATS_EN
    always_ff @(posedge clk) begin
        if (!`RESET_SIG) begin
            stat_alloc_cnt <= '0;
            stat_empty_cnt <= '0;
            stat_low_water <= '0;
        end else begin
            if (grant && pop)  stat_alloc_cnt <= stat_alloc_cnt + 32'd1;
            if (grant && !pop) stat_empty_cnt <= stat_empty_cnt + 32'd1;
            if ((state == ST_INIT) && (init_cnt == '1)) begin
                stat_low_water <= (BPTR_NBITS+1)'(1 << BPTR_NBITS);
            end else if (init_done && (free_cnt < stat_low_water)) begin
                stat_low_water <= free_cnt;
            end
        end
    end
`endif

endmodule
